// File: rtl/traffic_pkg.sv
// Shared lamp codes, controller states and default dwell times for the
// highway/country-road traffic-signal blocks.
package traffic_pkg;

   localparam logic [2:0] RED    = 3'd0;
   localparam logic [2:0] YELLOW = 3'd1;
   localparam logic [2:0] GREEN  = 3'd2;

   localparam int Y2R_DELAY_DFLT = 3;
   localparam int R2G_DELAY_DFLT = 2;

   typedef enum logic [2:0] {
      S0_HWY_GREEN   = 3'd0,
      S1_HWY_YELLOW  = 3'd1,
      S2_ALL_RED     = 3'd2,
      S3_CNTRY_GREEN = 3'd3,
      S4_CNTRY_YELLOW = 3'd4
   } state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/case_3.sv
// Case-3 traffic-light controller: Moore FSM that holds the highway green and
// yields to the country road through timed yellow / all-red intervals.
module case_3
   import traffic_pkg::*;
#(
   parameter int Y2R_DELAY = Y2R_DELAY_DFLT,
   parameter int R2G_DELAY = R2G_DELAY_DFLT
) (
   input  logic       CLOCK,
   input  logic       CLEAR,
   input  logic       CAR_ON_CNTRY_RD,
   output logic [2:0] MAIN_SIG,
   output logic [2:0] CNTRY_SIG
);

   localparam int CNT_W = $clog2(max_int(Y2R_DELAY, R2G_DELAY)) + 1;
   localparam logic [CNT_W-1:0] Y2R_LAST = CNT_W'(Y2R_DELAY - 1);
   localparam logic [CNT_W-1:0] R2G_LAST = CNT_W'(R2G_DELAY - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge CLOCK or negedge CLEAR) begin
      if (!CLEAR) begin
         state_q <= S0_HWY_GREEN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Counter is zero whenever a timed state is entered, so it only advances
   // while dwelling and is cleared on every exit.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      case (state_q)
         S0_HWY_GREEN: begin
            if (CAR_ON_CNTRY_RD) state_d = S1_HWY_YELLOW;
         end
         S1_HWY_YELLOW: begin
            if (cnt_q == Y2R_LAST) state_d = S2_ALL_RED;
            else                   cnt_d   = cnt_q + 1'b1;
         end
         S2_ALL_RED: begin
            if (cnt_q == R2G_LAST) state_d = S3_CNTRY_GREEN;
            else                   cnt_d   = cnt_q + 1'b1;
         end
         S3_CNTRY_GREEN: begin
            if (!CAR_ON_CNTRY_RD) state_d = S4_CNTRY_YELLOW;
         end
         S4_CNTRY_YELLOW: begin
            if (cnt_q == Y2R_LAST) state_d = S0_HWY_GREEN;
            else                   cnt_d   = cnt_q + 1'b1;
         end
         default: state_d = S0_HWY_GREEN;
      endcase
   end

   // Lamps decode from the state register only, so they cannot glitch on the sensor.
   always_comb begin
      MAIN_SIG  = GREEN;
      CNTRY_SIG = RED;
      case (state_q)
         S0_HWY_GREEN: begin
            MAIN_SIG  = GREEN;
            CNTRY_SIG = RED;
         end
         S1_HWY_YELLOW: begin
            MAIN_SIG  = YELLOW;
            CNTRY_SIG = RED;
         end
         S2_ALL_RED: begin
            MAIN_SIG  = RED;
            CNTRY_SIG = RED;
         end
         S3_CNTRY_GREEN: begin
            MAIN_SIG  = RED;
            CNTRY_SIG = GREEN;
         end
         S4_CNTRY_YELLOW: begin
            MAIN_SIG  = RED;
            CNTRY_SIG = YELLOW;
         end
         default: begin
            MAIN_SIG  = RED;
            CNTRY_SIG = RED;
         end
      endcase
   end

endmodule

// File: tb/tb_case_3.sv
// Directed bench for case_3: default-delay instance plus a Y2R=1 / R2G=4 instance.
module tb_case_3;

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic       car_a = 1'b0;
   logic       car_b = 1'b0;
   logic [2:0] main_a, cntry_a, main_b, cntry_b;
   int         n_tests = 0;
   int         n_fail  = 0;
   bit         mon_en  = 1'b0;

   always #5 clk = ~clk;

   case_3 u_dut_a (
      .CLOCK(clk), .CLEAR(clr), .CAR_ON_CNTRY_RD(car_a),
      .MAIN_SIG(main_a), .CNTRY_SIG(cntry_a)
   );

   case_3 #(.Y2R_DELAY(1), .R2G_DELAY(4)) u_dut_b (
      .CLOCK(clk), .CLEAR(clr), .CAR_ON_CNTRY_RD(car_b),
      .MAIN_SIG(main_b), .CNTRY_SIG(cntry_b)
   );

   task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         chk("dual_green_a", 3'((main_a == 3'd2) && (cntry_a == 3'd2)), 3'd0);
         chk("dual_green_b", 3'((main_b == 3'd2) && (cntry_b == 3'd2)), 3'd0);
      end
   end

   initial begin
      // Reset and idle
      step(5);
      chk("rst_main", main_a, 3'd2);
      chk("rst_cntry", cntry_a, 3'd0);
      clr = 1'b1;
      mon_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(1);
         chk("idle_main", main_a, 3'd2);
         chk("idle_cntry", cntry_a, 3'd0);
      end

      // Full cycle, sensor held 10 cycles
      car_a = 1'b1;
      step(1); chk("fc_e1_main", main_a, 3'd1); chk("fc_e1_cntry", cntry_a, 3'd0);
      step(2); chk("fc_e3_main", main_a, 3'd1);
      step(1); chk("fc_e4_main", main_a, 3'd0); chk("fc_e4_cntry", cntry_a, 3'd0);
      step(1); chk("fc_e5_cntry", cntry_a, 3'd0);
      step(1); chk("fc_e6_cntry", cntry_a, 3'd2); chk("fc_e6_main", main_a, 3'd0);
      step(4); chk("fc_e10_cntry", cntry_a, 3'd2);
      car_a = 1'b0;
      step(1); chk("fc_rel1_cntry", cntry_a, 3'd1); chk("fc_rel1_main", main_a, 3'd0);
      step(2); chk("fc_rel3_cntry", cntry_a, 3'd1);
      step(1); chk("fc_rel4_main", main_a, 3'd2); chk("fc_rel4_cntry", cntry_a, 3'd0);

      // Single-cycle pulse
      car_a = 1'b1;
      step(1); car_a = 1'b0;
      chk("sp_yel", main_a, 3'd1);
      step(3); chk("sp_red_main", main_a, 3'd0); chk("sp_red_cntry", cntry_a, 3'd0);
      step(2); chk("sp_grn", cntry_a, 3'd2);
      step(1); chk("sp_cyel", cntry_a, 3'd1);
      step(3); chk("sp_back_main", main_a, 3'd2); chk("sp_back_cntry", cntry_a, 3'd0);
      step(2); chk("sp_stay", main_a, 3'd2);

      // Sensor toggled while timed states run
      car_a = 1'b1;
      step(1); car_a = 1'b0;
      step(1); car_a = 1'b1;
      step(1); chk("ig_s1_end", main_a, 3'd1); car_a = 1'b1;
      step(1); chk("ig_s2_main", main_a, 3'd0); chk("ig_s2_cntry", cntry_a, 3'd0); car_a = 1'b0;
      step(1); chk("ig_s2_hold", cntry_a, 3'd0); car_a = 1'b1;
      step(1); chk("ig_s3", cntry_a, 3'd2);
      step(1); chk("ig_s3_hold", cntry_a, 3'd2); car_a = 1'b0;
      step(1); chk("ig_s4", cntry_a, 3'd1); car_a = 1'b1;
      step(1); chk("ig_s4_a", cntry_a, 3'd1); car_a = 1'b0;
      step(1); chk("ig_s4_b", cntry_a, 3'd1); car_a = 1'b1;
      step(1); chk("ig_s0", main_a, 3'd2); car_a = 1'b0;
      step(1); chk("ig_s0_hold", main_a, 3'd2);

      // Async reset mid-S3, between edges
      car_a = 1'b1;
      step(6); chk("ar_s3", cntry_a, 3'd2);
      #3;
      clr = 1'b0;
      #1;
      chk("ar_main", main_a, 3'd2);
      chk("ar_cntry", cntry_a, 3'd0);
      car_a = 1'b0;
      step(1); clr = 1'b1;
      step(2); chk("ar_post", main_a, 3'd2);

      // Y2R=1, R2G=4 instance
      car_b = 1'b1;
      step(1); car_b = 1'b0;
      chk("pb_yel", main_b, 3'd1);
      step(1); chk("pb_red_main", main_b, 3'd0); chk("pb_red_cntry", cntry_b, 3'd0);
      step(3); chk("pb_red_hold", cntry_b, 3'd0); chk("pb_red_hold_m", main_b, 3'd0);
      step(1); chk("pb_grn", cntry_b, 3'd2);
      step(1); chk("pb_cyel", cntry_b, 3'd1);
      step(1); chk("pb_back_main", main_b, 3'd2); chk("pb_back_cntry", cntry_b, 3'd0);

      step(2);
      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
